// File: rtl/msb_deserializer.sv
// Serial-to-parallel converter: MSB-first bits assemble into WIDTH-bit words held in a
// single-entry output register with a sticky overflow flag for words that could not be stored.
module msb_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_in,
    input  logic                     bit_valid,
    input  logic                     sync,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         word_out,
    output logic                     word_valid,
    output logic [$clog2(WIDTH)-1:0] bit_count,
    output logic                     overflow
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-2:0] r_shreg;
    logic [CW-1:0]    r_bit_count;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
    logic             r_overflow;

    logic [WIDTH-2:0] w_shreg_next;
    logic [CW-1:0]    w_bit_count_next;
    logic [WIDTH-1:0] w_word_next;
    logic             w_word_valid_next;
    logic             w_overflow_next;

    logic             w_accept;
    logic             w_last;
    logic             w_complete;
    logic             w_can_load;
    logic [WIDTH-1:0] w_assembled;

    // sync outranks bit_valid, so a bit presented alongside sync is discarded
    assign w_accept    = bit_valid & ~sync;
    assign w_last      = (r_bit_count == CW'(WIDTH - 1));
    assign w_complete  = w_accept & w_last;
    assign w_assembled = {r_shreg, bit_in};
    assign w_can_load  = ~r_word_valid | out_ready;

    always_comb begin
        w_shreg_next     = r_shreg;
        w_bit_count_next = r_bit_count;
        if (sync) begin
            w_shreg_next     = '0;
            w_bit_count_next = '0;
        end else if (bit_valid) begin
            w_shreg_next     = w_assembled[WIDTH-2:0];
            w_bit_count_next = w_last ? '0 : r_bit_count + CW'(1);
        end
    end

    always_comb begin
        w_word_next       = r_word;
        w_word_valid_next = r_word_valid;
        w_overflow_next   = r_overflow;
        if (w_complete && w_can_load) begin
            w_word_next       = w_assembled;
            w_word_valid_next = 1'b1;
        end else begin
            if (out_ready) begin
                w_word_valid_next = 1'b0;
            end
            // a finished word with nowhere to go is lost; the held word stays
            if (w_complete) begin
                w_overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg      <= '0;
            r_bit_count  <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_shreg      <= w_shreg_next;
            r_bit_count  <= w_bit_count_next;
            r_word       <= w_word_next;
            r_word_valid <= w_word_valid_next;
            r_overflow   <= w_overflow_next;
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_word_valid;
    assign bit_count  = r_bit_count;
    assign overflow   = r_overflow;

endmodule

// File: doc/msb_deserializer.md
MSB_DESERIALIZER -- requirements
Module: msb_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the word width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset; the clock is clk, single clock domain.
REQ-004 SHALL have port bit_in  input  1  serial data bit, MSB of each word first.
REQ-005 SHALL have port bit_valid  input  1  bit_in is accepted on this clock edge.
REQ-006 SHALL have port sync  input  1  restart word alignment: discard any partial word.
REQ-007 SHALL have port out_ready  input  1  consumer accepts word_out this cycle.
REQ-008 SHALL have port word_out  output  WIDTH  assembled word; first received bit at bit WIDTH-1.
REQ-009 SHALL have port word_valid  output  1  word_out holds an unconsumed word.
REQ-010 SHALL have port bit_count  output  $clog2(WIDTH)  number of bits of the current partial word received so far.
REQ-011 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 SHALL accept bit_in always: bit_valid=1 with sync=0 shifts it in (shreg <= {shreg[WIDTH-2:0], bit_in}), independent of word_valid; there is no backpressure on the serial side.
REQ-013 SHALL increment bit_count on each accepted bit; the accepted bit with bit_count==WIDTH-1 completes a word and wraps bit_count to 0.
REQ-014 SHALL form the completed word as {shreg[WIDTH-2:0], bit_in} and present it on word_out with word_valid=1 on the cycle after the completing edge (latency 1 clock from the last bit).
REQ-015 SHALL load a completed word into the output register only when the register is empty (word_valid=0) or is being consumed on the same edge (word_valid=1 and out_ready=1).
REQ-016 SHALL keep word_valid high, with word_out unchanged, until an edge with out_ready=1; if no new word loads on that edge, word_valid then clears.
REQ-017 SHALL drop a completed word that cannot be loaded (word_valid=1, out_ready=0), leave the held word intact, and set overflow=1.
REQ-018 SHALL hold overflow at 1 until reset.
REQ-019 SHALL, on sync=1, clear shreg and bit_count to 0 and discard any bit_in presented on that edge, even when bit_valid=1 (sync has priority).
REQ-020 SHALL leave the output register, word_valid and overflow unaffected by sync.
REQ-021 SHALL treat out_ready while word_valid=0 as a no-op.
REQ-022 SHALL treat a completed word and consumption on the same edge as back-to-back: the new word replaces the old and word_valid stays 1 with no gap.
REQ-023 SHALL ignore bit_in whenever bit_valid=0; shreg and bit_count hold.
REQ-024 SHALL permit bit_valid to assert on consecutive cycles, giving one word every WIDTH cycles at full rate with zero loss when out_ready=1.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, force shreg=0, bit_count=0, word_out=0, word_valid=0 and overflow=0.
REQ-026 SHALL discard any partial word received before a reset asserted mid-word; after reset deasserts, the first accepted bit is bit WIDTH-1 of a new word.
REQ-027 SHALL ignore all inputs while reset=1.

Verification
REQ-028 SHALL be covered by scenario: after reset, bits 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=1 -> word_out=0xA5 and word_valid=1 for exactly one cycle, 1 clock after the 8th bit; bit_count=0.
REQ-029 SHALL be covered by scenario: bit streams 0xA5 then 0x3C back-to-back with out_ready=1 -> 0xA5 then 0x3C, each valid for one cycle, 8 cycles apart, overflow=0.
REQ-030 SHALL be covered by scenario: out_ready=0, send 0xA5 then 0x3C -> word_out stays 0xA5 with word_valid=1 and overflow=1; then out_ready=1 for one cycle -> word_valid=0 and overflow still 1.
REQ-031 SHALL be covered by scenario: send 1,1,1, then sync=1 with bit_valid=1 and bit_in=1, then 0x3C MSB-first -> word_out=0x3C, never 0xFx; bit_count=0 on the cycle after sync.
REQ-032 SHALL be covered by scenario: send 5 bits of 0xFF, assert reset for a non-clock-aligned 3 ns, then send 0x81 -> word_out=0x81, and all outputs are 0 during reset.
REQ-033 SHALL be covered by scenario: word 0x3C held with out_ready=0, then 0x5A's last bit arrives on the same edge that out_ready=1 -> word_out=0x5A next cycle, word_valid never drops, overflow=0.
